// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, Rcon table, S-box, GF(2^8)
// helpers, word/state typedefs and the core FSM state encoding.
package aes_pkg;

   localparam int unsigned NR = 10;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } fsm_e;

   localparam logic [7:0] RCON [NR] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // S-box stored as 16 rows of 16 bytes; row = high nibble, first byte in the MSBs
   localparam logic [127:0] SBOX_ROW [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [127:0] row;
      row = SBOX_ROW[b[7:4]];
      // column n sits at bit offset 8*(15-n) == {~n, 3'b000}
      return row[{~b[3:0], 3'b000} +: 8];
   endfunction

   // Rcon for round 1..NR; zero outside that range
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      if (r >= 4'd1 && r <= 4'(NR)) v = RCON[r - 4'd1];
      return v;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Handshake bundle for aes_iter_core.
//   slave  : core side (accepts pt/key, presents ct/last_key)
//   master : system side
interface aes_iter_core_if;
   import aes_pkg::*;

   logic   in_valid;
   logic   in_ready;
   state_t pt_in;
   state_t key_in;
   logic   out_valid;
   logic   out_ready;
   state_t ct_out;
   state_t last_key;

   modport slave (
      input  in_valid, pt_in, key_in, out_ready,
      output in_ready, out_valid, ct_out, last_key
   );

   modport master (
      output in_valid, pt_in, key_in, out_ready,
      input  in_ready, out_valid, ct_out, last_key
   );

endinterface

// File: rtl/aes_round_slice.sv
// One combinational AES-128 round with its on-the-fly key expansion step.
//   state_i    : state entering the round
//   key_i      : round key k[r-1]
//   round_i    : round index r (selects Rcon)
//   is_final_i : skip MixColumns (last round)
//   state_c_o  : state after AddRoundKey k[r]
//   key_c_o    : round key k[r]
module aes_round_slice
   import aes_pkg::*;
(
   input  state_t     state_i,
   input  state_t     key_i,
   input  logic [3:0] round_i,
   input  logic       is_final_i,
   output state_t     state_c_o,
   output state_t     key_c_o
);

   word_t      w0, w1, w2, w3, tmp, n0, n1, n2, n3;
   state_t     rk, res;
   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mx [16];

   // Key expansion: SubWord(RotWord(w3)) ^ Rcon, then cascade across words
   always_comb begin
      w0  = key_i[127:96];
      w1  = key_i[95:64];
      w2  = key_i[63:32];
      w3  = key_i[31:0];
      tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
            ^ {rcon(round_i), 24'h000000};
      n0  = w0 ^ tmp;
      n1  = w1 ^ n0;
      n2  = w2 ^ n1;
      n3  = w3 ^ n2;
      rk  = {n0, n1, n2, n3};
   end

   // SubBytes, ShiftRows, MixColumns (bypassed in the final round), AddRoundKey
   always_comb begin
      res = '0;
      for (int i = 0; i < 16; i++) sb[i] = sbox(state_i[8*(15-i) +: 8]);
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
      for (int c = 0; c < 4; c++) begin
         mx[4*c+0] = gmul2(sr[4*c]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
         mx[4*c+1] = sr[4*c] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
         mx[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
         mx[4*c+3] = gmul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
      end
      for (int i = 0; i < 16; i++) begin
         res[8*(15-i) +: 8] = (is_final_i ? sr[i] : mx[i]) ^ rk[8*(15-i) +: 8];
      end
   end

   assign state_c_o = res;
   assign key_c_o   = rk;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock (1, 2, 5 or 10).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave handshake port (pt/key in, ciphertext and round-10 key out)
module aes_iter_core
   import aes_pkg::*;
#(
   parameter int unsigned UNROLL = 1
) (
   input logic            clk,
   input logic            rst,
   aes_iter_core_if.slave bus
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
      $error("aes_iter_core: UNROLL must be 1, 2, 5 or 10");
   end

   fsm_e       fsm_q, fsm_d;
   logic [3:0] round_q, round_d;
   state_t     state_q, state_d;
   state_t     key_q, key_d;
   state_t     ct_q, ct_d;
   state_t     last_key_q, last_key_d;
   logic       out_valid_q, out_valid_d;
   logic       in_ready_q, in_ready_d;
   logic       last_c;

   state_t     chain_st  [UNROLL+1];
   state_t     chain_key [UNROLL+1];

   // Slices for rounds round_q .. round_q+UNROLL-1 chained in one cycle
   assign chain_st[0]  = state_q;
   assign chain_key[0] = key_q;

   for (genvar g = 0; g < int'(UNROLL); g++) begin : g_slice
      logic [3:0] rnd;
      assign rnd = round_q + 4'(g);
      aes_round_slice u_slice (
         .state_i    (chain_st[g]),
         .key_i      (chain_key[g]),
         .round_i    (rnd),
         .is_final_i (rnd == 4'(NR)),
         .state_c_o  (chain_st[g+1]),
         .key_c_o    (chain_key[g+1])
      );
   end

   // Final group of slices reaches round NR this cycle
   assign last_c = (round_q + 4'(UNROLL - 1)) == 4'(NR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= ST_IDLE;
         round_q     <= '0;
         state_q     <= '0;
         key_q       <= '0;
         ct_q        <= '0;
         last_key_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         round_q     <= round_d;
         state_q     <= state_d;
         key_q       <= key_d;
         ct_q        <= ct_d;
         last_key_q  <= last_key_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      round_d     = round_q;
      state_d     = state_q;
      key_d       = key_q;
      ct_d        = ct_q;
      last_key_d  = last_key_q;
      out_valid_d = out_valid_q;
      in_ready_d  = 1'b0;
      case (fsm_q)
         ST_IDLE: begin
            if (in_ready_q && bus.in_valid) begin
               state_d = bus.pt_in ^ bus.key_in;
               key_d   = bus.key_in;
               round_d = 4'd1;
               fsm_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            state_d = chain_st[UNROLL];
            key_d   = chain_key[UNROLL];
            round_d = round_q + 4'(UNROLL);
            if (last_c) begin
               // counter parks at 0 so it never runs past NR
               round_d     = 4'd0;
               ct_d        = chain_st[UNROLL];
               last_key_d  = chain_key[UNROLL];
               out_valid_d = 1'b1;
               fsm_d       = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
      in_ready_d = (fsm_d == ST_IDLE);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.ct_out    = ct_q;
   assign bus.last_key  = last_key_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: FIPS-197 vectors, UNROLL sweep, backpressure,
// busy-input rejection, mid-operation reset and back-to-back streaming.
module tb_aes_iter_core;
   import aes_pkg::*;

   localparam state_t B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam state_t B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam state_t B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam state_t B_LK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam state_t C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam state_t C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam state_t C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam state_t C_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   typedef struct packed {
      state_t ct;
      state_t lk;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last_acc = 0;
   exp_t sb_q[$];

   aes_iter_core_if ifc1 ();
   aes_iter_core_if ifc2 ();
   aes_iter_core_if ifc5 ();
   aes_iter_core_if ifc10 ();

   aes_iter_core #(.UNROLL(1))  u_dut1  (.clk(clk), .rst(rst), .bus(ifc1));
   aes_iter_core #(.UNROLL(2))  u_dut2  (.clk(clk), .rst(rst), .bus(ifc2));
   aes_iter_core #(.UNROLL(5))  u_dut5  (.clk(clk), .rst(rst), .bus(ifc5));
   aes_iter_core #(.UNROLL(10)) u_dut10 (.clk(clk), .rst(rst), .bus(ifc10));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Offer a pair on ifc1 until accepted; queue its expected result
   task automatic send(input state_t pt, input state_t key, input state_t ect, input state_t elk);
      bit   got;
      exp_t e;
      got = 1'b0;
      ifc1.pt_in    = pt;
      ifc1.key_in   = key;
      ifc1.in_valid = 1'b1;
      for (int n = 0; n < 40; n++) begin
         if (ifc1.in_ready === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready=%b, required 1", ifc1.in_ready);
         ifc1.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         last_acc = cyc;
         e.ct = ect;
         e.lk = elk;
         sb_q.push_back(e);
         #1 ifc1.in_valid = 1'b0;
      end
   endtask

   // Counts clock edges after the accept edge until out_valid is seen
   task automatic wait_out(output int cycles, output bit ok);
      ok = 1'b0;
      cycles = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (ifc1.out_valid === 1'b1) begin ok = 1'b1; break; end
         cycles++;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL out_timeout: out_valid=%b after 40 cycles, required 1", ifc1.out_valid);
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++; if (ifc1.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", ifc1.in_ready); end
      checks++; if (ifc1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", ifc1.out_valid); end
      checks++; if (ifc1.ct_out !== '0) begin errors++; $display("FAIL rst_ct: got %h, required 0", ifc1.ct_out); end
      checks++; if (ifc1.last_key !== '0) begin errors++; $display("FAIL rst_last_key: got %h, required 0", ifc1.last_key); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ifc1.in_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_in_ready: got %b, required 0", ifc1.in_ready); end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      checks++; if (ifc1.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", ifc1.in_ready); end
   endtask

   task automatic test_fips_b();
      int   lat;
      bit   ok;
      exp_t e;
      send(B_PT, B_KEY, B_CT, B_LK);
      wait_out(lat, ok);
      if (ok) begin
         checks++; if (lat != 10) begin errors++; $display("FAIL b_latency: got %0d, required 10", lat); end
         e = sb_q.pop_front();
         checks++; if (ifc1.ct_out !== e.ct) begin errors++; $display("FAIL b_ct: got %h, required %h", ifc1.ct_out, e.ct); end
         checks++; if (ifc1.last_key !== e.lk) begin errors++; $display("FAIL b_last_key: got %h, required %h", ifc1.last_key, e.lk); end
      end else sb_q.delete();
      ifc1.out_ready = 1'b1;
      @(negedge clk);
      ifc1.out_ready = 1'b0;
      checks++; if (ifc1.out_valid !== 1'b0) begin errors++; $display("FAIL b_ov_drop: got %b, required 0", ifc1.out_valid); end
      checks++; if (ifc1.in_ready !== 1'b1) begin errors++; $display("FAIL b_in_ready: got %b, required 1", ifc1.in_ready); end
   endtask

   task automatic test_unroll_sweep();
      int     lat [4];
      state_t cts [4];
      int     exp_lat [4];
      exp_t   e;
      exp_lat = '{10, 5, 2, 1};
      lat     = '{-1, -1, -1, -1};
      cts     = '{'0, '0, '0, '0};
      ifc1.pt_in = C_PT;  ifc1.key_in = C_KEY;
      ifc2.pt_in = C_PT;  ifc2.key_in = C_KEY;
      ifc5.pt_in = C_PT;  ifc5.key_in = C_KEY;
      ifc10.pt_in = C_PT; ifc10.key_in = C_KEY;
      checks++;
      if ({ifc1.in_ready, ifc2.in_ready, ifc5.in_ready, ifc10.in_ready} !== 4'b1111) begin
         errors++;
         $display("FAIL sweep_in_ready: got %b%b%b%b, required 1111",
                  ifc1.in_ready, ifc2.in_ready, ifc5.in_ready, ifc10.in_ready);
      end
      ifc1.in_valid = 1'b1; ifc2.in_valid = 1'b1; ifc5.in_valid = 1'b1; ifc10.in_valid = 1'b1;
      @(posedge clk);
      e.ct = C_CT;
      e.lk = C_LK;
      sb_q.push_back(e);
      #1;
      ifc1.in_valid = 1'b0; ifc2.in_valid = 1'b0; ifc5.in_valid = 1'b0; ifc10.in_valid = 1'b0;
      for (int n = 0; n <= 20; n++) begin
         @(negedge clk);
         if (ifc1.out_valid === 1'b1 && lat[0] < 0)  begin lat[0] = n; cts[0] = ifc1.ct_out;  end
         if (ifc2.out_valid === 1'b1 && lat[1] < 0)  begin lat[1] = n; cts[1] = ifc2.ct_out;  end
         if (ifc5.out_valid === 1'b1 && lat[2] < 0)  begin lat[2] = n; cts[2] = ifc5.ct_out;  end
         if (ifc10.out_valid === 1'b1 && lat[3] < 0) begin lat[3] = n; cts[3] = ifc10.ct_out; end
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (lat[i] != exp_lat[i]) begin errors++; $display("FAIL sweep_latency[%0d]: got %0d, required %0d", i, lat[i], exp_lat[i]); end
         checks++; if (cts[i] !== C_CT) begin errors++; $display("FAIL sweep_ct[%0d]: got %h, required %h", i, cts[i], C_CT); end
      end
      e = sb_q.pop_front();
      checks++; if (ifc1.last_key !== e.lk) begin errors++; $display("FAIL c_last_key: got %h, required %h", ifc1.last_key, e.lk); end
      ifc1.out_ready = 1'b1;
      @(negedge clk);
      ifc1.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int   lat;
      bit   ok;
      exp_t e;
      send(B_PT, B_KEY, B_CT, B_LK);
      wait_out(lat, ok);
      e = sb_q.pop_front();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         checks++; if (ifc1.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b, required 1", k, ifc1.out_valid); end
         checks++; if (ifc1.ct_out !== e.ct) begin errors++; $display("FAIL bp_ct[%0d]: got %h, required %h", k, ifc1.ct_out, e.ct); end
         checks++; if (ifc1.last_key !== e.lk) begin errors++; $display("FAIL bp_last_key[%0d]: got %h, required %h", k, ifc1.last_key, e.lk); end
         checks++; if (ifc1.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", k, ifc1.in_ready); end
      end
      ifc1.out_ready = 1'b1;
      @(negedge clk);
      ifc1.out_ready = 1'b0;
      checks++; if (ifc1.out_valid !== 1'b0) begin errors++; $display("FAIL bp_ov_drop: got %b, required 0", ifc1.out_valid); end
      checks++; if (ifc1.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %b, required 1", ifc1.in_ready); end
   endtask

   task automatic test_ignore_busy();
      int   lat;
      bit   ok;
      bit   extra;
      exp_t e;
      send(C_PT, C_KEY, C_CT, C_LK);
      @(negedge clk);
      ifc1.pt_in    = B_PT ^ 128'h1;
      ifc1.key_in   = B_KEY;
      ifc1.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      ifc1.in_valid = 1'b0;
      wait_out(lat, ok);
      e = sb_q.pop_front();
      checks++; if (ifc1.ct_out !== e.ct) begin errors++; $display("FAIL busy_ct: got %h, required %h", ifc1.ct_out, e.ct); end
      checks++; if (ifc1.last_key !== e.lk) begin errors++; $display("FAIL busy_last_key: got %h, required %h", ifc1.last_key, e.lk); end
      ifc1.out_ready = 1'b1;
      @(negedge clk);
      ifc1.out_ready = 1'b0;
      extra = 1'b0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (ifc1.out_valid !== 1'b0) extra = 1'b1;
      end
      checks++; if (extra !== 1'b0) begin errors++; $display("FAIL busy_second_result: got %b, required 0", extra); end
   endtask

   task automatic test_reset_mid();
      int   lat;
      bit   ok;
      exp_t e;
      send(B_PT, B_KEY, B_CT, B_LK);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      sb_q.delete();
      checks++; if (ifc1.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ov: got %b, required 0", ifc1.out_valid); end
      checks++; if (ifc1.ct_out !== '0) begin errors++; $display("FAIL mid_rst_ct: got %h, required 0", ifc1.ct_out); end
      checks++; if (ifc1.last_key !== '0) begin errors++; $display("FAIL mid_rst_last_key: got %h, required 0", ifc1.last_key); end
      checks++; if (ifc1.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b, required 0", ifc1.in_ready); end
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      checks++; if (ifc1.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_partial: got %b, required 0", ifc1.out_valid); end
      send(B_PT, B_KEY, B_CT, B_LK);
      wait_out(lat, ok);
      if (ok) begin
         e = sb_q.pop_front();
         checks++; if (lat != 10) begin errors++; $display("FAIL mid_rst_latency: got %0d, required 10", lat); end
         checks++; if (ifc1.ct_out !== e.ct) begin errors++; $display("FAIL mid_rst_ct_after: got %h, required %h", ifc1.ct_out, e.ct); end
      end else sb_q.delete();
      ifc1.out_ready = 1'b1;
      @(negedge clk);
      ifc1.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int   lat;
      bit   ok;
      int   acc0;
      exp_t e;
      ifc1.out_ready = 1'b1;
      send(B_PT, B_KEY, B_CT, B_LK);
      acc0 = last_acc;
      wait_out(lat, ok);
      if (ok) begin
         e = sb_q.pop_front();
         checks++; if (ifc1.ct_out !== e.ct) begin errors++; $display("FAIL b2b_ct0: got %h, required %h", ifc1.ct_out, e.ct); end
      end
      send(C_PT, C_KEY, C_CT, C_LK);
      checks++; if (last_acc - acc0 != 12) begin errors++; $display("FAIL b2b_spacing: got %0d, required 12", last_acc - acc0); end
      wait_out(lat, ok);
      if (ok && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++; if (ifc1.ct_out !== e.ct) begin errors++; $display("FAIL b2b_ct1: got %h, required %h", ifc1.ct_out, e.ct); end
      end
      @(negedge clk);
      ifc1.out_ready = 1'b0;
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_queue_empty: got %0d, required 0", sb_q.size()); end
   endtask

   initial begin
      ifc1.in_valid = 1'b0;  ifc1.pt_in = '0;  ifc1.key_in = '0;  ifc1.out_ready = 1'b0;
      ifc2.in_valid = 1'b0;  ifc2.pt_in = '0;  ifc2.key_in = '0;  ifc2.out_ready = 1'b1;
      ifc5.in_valid = 1'b0;  ifc5.pt_in = '0;  ifc5.key_in = '0;  ifc5.out_ready = 1'b1;
      ifc10.in_valid = 1'b0; ifc10.pt_in = '0; ifc10.key_in = '0; ifc10.out_ready = 1'b1;
      test_reset();
      test_fips_b();
      test_unroll_sweep();
      test_backpressure();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time=%0t, required finish before 100000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
